// File: rtl/alsu_op_scheduler.sv
// Shares one ALSU datapath between two requesters, one op in flight,
// capturing out/leds a fixed latency after issue and returning them tagged.
module alsu_op_scheduler #(
    parameter int ALSU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [15:0]       req0_cmd,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [15:0]       req1_cmd,
    output logic              req1_ready,
    output logic [15:0]       alsu_cmd,
    input  logic signed [5:0] alsu_out,
    input  logic [15:0]       alsu_leds,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic signed [5:0] rsp_out,
    output logic [15:0]       rsp_leds,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(ALSU_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       prio;
    logic [2:0] cnt;
    logic       idle;

    assign idle = (state == IDLE);

    // prio names the requester that wins a tie
    assign req0_ready = idle && req0_valid && (!req1_valid || !prio);
    assign req1_ready = idle && req1_valid && (!req0_valid || prio);

    assign rsp_valid = (state == RESP);
    assign busy      = !idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (req0_ready || req1_ready) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (cnt == 3'd0) state_nxt = RESP;
            RESP:  if (rsp_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alsu_cmd <= 16'h0000;
            rsp_id   <= 1'b0;
            rsp_out  <= 6'sd0;
            rsp_leds <= 16'h0000;
            rsp_err  <= 1'b0;
            prio     <= 1'b0;
            cnt      <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0_ready) begin
                        alsu_cmd <= req0_cmd;
                        rsp_id   <= 1'b0;
                        prio     <= 1'b1;
                    end else if (req1_ready) begin
                        alsu_cmd <= req1_cmd;
                        rsp_id   <= 1'b1;
                        prio     <= 1'b0;
                    end
                end
                ISSUE: cnt <= CNT_INIT;
                WAIT: begin
                    if (cnt == 3'd0) begin
                        rsp_out  <= alsu_out;
                        rsp_leds <= alsu_leds;
                        rsp_err  <= |alsu_leds;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: ;
            endcase
        end
    end

endmodule
